// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 64;
  localparam int RF_PPP_W  = 3;

  // Part-select code for a full-width register write.
  localparam logic [0:RF_PPP_W-1] PPP_ALL = 3'b000;

  // One queued register-file write; all fields MSB-at-bit-0.
  typedef struct packed {
    logic [0:RF_ADDR_W-1] rd;
    logic [0:RF_PPP_W-1]  ppp;
    logic [0:RF_DATA_W-1] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Per-requester write-back FIFO. Exposes per-slot valid bits and destination
// registers so the arbiter can detect pending writes to any register.
import rf_pkg::*;

module rf_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 push_i,
  input  rf_wr_t                               din_i,
  input  logic                                 pop_i,
  output rf_wr_t                               dout_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [DEPTH-1:0]                     ent_vld_o,
  output logic [DEPTH-1:0][0:RF_ADDR_W-1]      ent_rd_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rf_wr_t           mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             do_push, do_pop;

  assign full_o    = &vld_q;
  assign empty_o   = ~|vld_q;
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign dout_o    = mem_q[rp_q];
  assign ent_vld_o = vld_q;

  // Per-slot valid bits: push never targets the popped slot because a full
  // FIFO refuses pushes and an empty one refuses pops.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    vld_d = vld_q;
    if (do_push) begin
      vld_d[wp_q] = 1'b1;
      wp_d        = wp_q + PW'(1);
    end
    if (do_pop) begin
      vld_d[rp_q] = 1'b0;
      rp_d        = rp_q + PW'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vld_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      vld_q <= vld_d;
    end
  end

  // Entry storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  // Destination register of every slot for the hazard compare.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) ent_rd_o[i] = mem_q[i].rd;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two buffered requesters share the single
// RF write port; reports pending writes for the two read addresses.
// Optional macro RF_WB_RR_EN selects round-robin arbitration (default: fixed
// priority, requester 0 wins).
import rf_pkg::*;

module rf_wb_arbiter #(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [0:ADDR_W-1] req0_rd,
  input  logic [0:2]        req0_ppp,
  input  logic [0:DATA_W-1] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [0:ADDR_W-1] req1_rd,
  input  logic [0:2]        req1_ppp,
  input  logic [0:DATA_W-1] req1_data,
  output logic              rf_wrEn,
  output logic [0:ADDR_W-1] rf_rD,
  output logic [0:2]        rf_ppp,
  output logic [0:DATA_W-1] rf_d_in,
  input  logic [0:ADDR_W-1] query_rA,
  input  logic [0:ADDR_W-1] query_rB,
  output logic              busy_A,
  output logic              busy_B,
  output logic              idle
);

  rf_wr_t                          din0, din1, head0, head1;
  logic                            full0, full1, empty0, empty1;
  logic                            push0, push1, pop0, pop1;
  logic [DEPTH-1:0]                vld0, vld1;
  logic [DEPTH-1:0][0:ADDR_W-1]    erd0, erd1;
  logic                            wr_en_q, wr_en_d;
  rf_wr_t                          wr_q, wr_d;

  // Ready depends only on occupancy (and reset), never on valid.
  assign req0_ready = reset & ~full0;
  assign req1_ready = reset & ~full1;
  assign push0      = req0_valid & req0_ready;
  assign push1      = req1_valid & req1_ready;
  assign din0       = '{rd: req0_rd, ppp: req0_ppp, data: req0_data};
  assign din1       = '{rd: req1_rd, ppp: req1_ppp, data: req1_data};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk_i(clk), .rst_ni(reset), .push_i(push0), .din_i(din0), .pop_i(pop0),
    .dout_o(head0), .full_o(full0), .empty_o(empty0),
    .ent_vld_o(vld0), .ent_rd_o(erd0)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk_i(clk), .rst_ni(reset), .push_i(push1), .din_i(din1), .pop_i(pop1),
    .dout_o(head1), .full_o(full1), .empty_o(empty1),
    .ent_vld_o(vld1), .ent_rd_o(erd1)
  );

`ifdef RF_WB_RR_EN
  logic last_q, last_d;  // 1 = requester 1 was granted most recently

  // Round-robin grant: on contention favour the requester not granted last.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (!empty0 && !empty1) begin
      if (last_q) pop0 = 1'b1;
      else        pop1 = 1'b1;
    end else begin
      pop0 = !empty0;
      pop1 = !empty1;
    end
  end

  // Last-grant pointer moves only when something is granted.
  always_comb begin
    last_d = last_q;
    if (pop0)      last_d = 1'b0;
    else if (pop1) last_d = 1'b1;
  end

  // Last-grant register; reset so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  // Fixed-priority grant: requester 0 always wins.
  always_comb begin
    pop0 = !empty0;
    pop1 = empty0 && !empty1;
  end
`endif

  // Next RF write: granted head, or hold last fields with write disabled.
  always_comb begin
    wr_en_d = pop0 | pop1;
    wr_d    = wr_q;
    if (pop0)      wr_d = head0;
    else if (pop1) wr_d = head1;
  end

  // Registered RF write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en_q <= 1'b0;
      wr_q    <= '{rd: '0, ppp: PPP_ALL, data: '0};
    end else begin
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
    end
  end

  assign rf_wrEn = wr_en_q;
  assign rf_rD   = wr_q.rd;
  assign rf_ppp  = wr_q.ppp;
  assign rf_d_in = wr_q.data;
  assign idle    = empty0 & empty1 & ~wr_en_q;

  // Pending-write hazard: any queued entry or the write currently on the port.
  always_comb begin
    busy_A = wr_en_q && (wr_q.rd == query_rA);
    busy_B = wr_en_q && (wr_q.rd == query_rB);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_A = busy_A | (vld0[i] && (erd0[i] == query_rA))
                      | (vld1[i] && (erd1[i] == query_rA));
      busy_B = busy_B | (vld0[i] && (erd0[i] == query_rB))
                      | (vld1[i] && (erd1[i] == query_rB));
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: table-driven cycle vectors plus
// hand-written contention/backpressure and reset-mid-stream sequences.
`timescale 1ns/1ps

module tb_rf_wb_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  localparam logic [63:0] DA = 64'd1555555587;
  localparam logic [63:0] DB = 64'd1777777777;
  localparam logic [63:0] DC = 64'h0123456789ABCDEF;
  localparam logic [63:0] DD = 64'hFEDCBA9876543210;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [0:AW-1] req0_rd, req1_rd;
  logic [0:2]    req0_ppp, req1_ppp;
  logic [0:DW-1] req0_data, req1_data;
  logic          rf_wrEn;
  logic [0:AW-1] rf_rD;
  logic [0:2]    rf_ppp;
  logic [0:DW-1] rf_d_in;
  logic [0:AW-1] query_rA, query_rB;
  logic          busy_A, busy_B, idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd),
    .req0_ppp(req0_ppp), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd),
    .req1_ppp(req1_ppp), .req1_data(req1_data),
    .rf_wrEn(rf_wrEn), .rf_rD(rf_rD), .rf_ppp(rf_ppp), .rf_d_in(rf_d_in),
    .query_rA(query_rA), .query_rB(query_rB),
    .busy_A(busy_A), .busy_B(busy_B), .idle(idle)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v0; logic [4:0] rd0; logic [2:0] ppp0; logic [63:0] d0;
    logic v1; logic [4:0] rd1; logic [2:0] ppp1; logic [63:0] d1;
    logic [4:0] qa; logic [4:0] qb;
    logic rdy0; logic rdy1; logic wren; logic [4:0] rdx; logic [2:0] pppx;
    logic [63:0] dx; logic ba; logic bb; logic idl;
  } vec_t;

  vec_t vec [14];

  task automatic drive_idle();
    req0_valid = 1'b0; req0_rd = '0; req0_ppp = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_ppp = '0; req1_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [4:0]  seq [12];
    logic [63:0] exp_d;
    logic [4:0]  exp_rd;
    int n0, n1, iss, first, last, drop_at;
    bit hs0, hs1, drop_seen;

    //   v0 rd0 ppp0 d0  v1 rd1 ppp1 d1  qa qb  rdy0 rdy1 wren rdx pppx dx  ba bb idle
    // Same-register race (rd=4 from both requesters).
    vec[0]  = '{1, 4, 0, DA, 1, 4, 0, DB, 4, 5, 1, 1, 0, 0, 0, 0,  0, 0, 1};
    vec[1]  = '{0, 0, 0, 0,  0, 0, 0, 0,  4, 5, 1, 1, 0, 0, 0, 0,  1, 0, 0};
    vec[2]  = '{0, 0, 0, 0,  0, 0, 0, 0,  4, 5, 1, 1, 1, 4, 0, DA, 1, 0, 0};
    vec[3]  = '{0, 0, 0, 0,  0, 0, 0, 0,  4, 5, 1, 1, 1, 4, 0, DB, 1, 0, 0};
    vec[4]  = '{0, 0, 0, 0,  0, 0, 0, 0,  4, 5, 1, 1, 0, 4, 0, DB, 0, 0, 1};
    // Single uncontested write to rd=3.
    vec[5]  = '{1, 3, 0, DB, 0, 0, 0, 0,  3, 4, 1, 1, 0, 4, 0, DB, 0, 0, 1};
    vec[6]  = '{0, 0, 0, 0,  0, 0, 0, 0,  3, 4, 1, 1, 0, 4, 0, DB, 1, 0, 0};
    vec[7]  = '{0, 0, 0, 0,  0, 0, 0, 0,  3, 4, 1, 1, 1, 3, 0, DB, 1, 0, 0};
    vec[8]  = '{0, 0, 0, 0,  0, 0, 0, 0,  3, 4, 1, 1, 0, 3, 0, DB, 0, 0, 1};
    // Part-select pass-through (ppp 011 and 100).
    vec[9]  = '{1, 7, 3, DC, 0, 0, 0, 0,  7, 9, 1, 1, 0, 3, 0, DB, 0, 0, 1};
    vec[10] = '{0, 0, 0, 0,  1, 9, 4, DD, 7, 9, 1, 1, 0, 3, 0, DB, 1, 0, 0};
    vec[11] = '{0, 0, 0, 0,  0, 0, 0, 0,  7, 9, 1, 1, 1, 7, 3, DC, 1, 1, 0};
    vec[12] = '{0, 0, 0, 0,  0, 0, 0, 0,  7, 9, 1, 1, 1, 9, 4, DD, 0, 1, 0};
    vec[13] = '{0, 0, 0, 0,  0, 0, 0, 0,  7, 9, 1, 1, 0, 9, 4, DD, 0, 0, 1};

    // ---------------- reset state ----------------
    drive_idle();
    query_rA = '0;
    query_rB = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wrEn",  64'(rf_wrEn), 64'd0);
    chk("rst_rD",    64'(rf_rD), 64'd0);
    chk("rst_ppp",   64'(rf_ppp), 64'd0);
    chk("rst_d_in",  64'(rf_d_in), 64'd0);
    chk("rst_busyA", 64'(busy_A), 64'd0);
    chk("rst_busyB", 64'(busy_B), 64'd0);
    chk("rst_idle",  64'(idle), 64'd1);
    chk("rst_rdy0",  64'(req0_ready), 64'd0);
    chk("rst_rdy1",  64'(req1_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_rdy0", 64'(req0_ready), 64'd1);
    chk("post_rst_rdy1", 64'(req1_ready), 64'd1);

    // ---------------- table-driven cycles ----------------
    for (int i = 0; i < 14; i++) begin
      req0_valid = vec[i].v0; req0_rd = vec[i].rd0; req0_ppp = vec[i].ppp0; req0_data = vec[i].d0;
      req1_valid = vec[i].v1; req1_rd = vec[i].rd1; req1_ppp = vec[i].ppp1; req1_data = vec[i].d1;
      query_rA = vec[i].qa;
      query_rB = vec[i].qb;
      #1;
      chk($sformatf("v%0d_rdy0", i),  64'(req0_ready), 64'(vec[i].rdy0));
      chk($sformatf("v%0d_rdy1", i),  64'(req1_ready), 64'(vec[i].rdy1));
      chk($sformatf("v%0d_wrEn", i),  64'(rf_wrEn),    64'(vec[i].wren));
      chk($sformatf("v%0d_rD", i),    64'(rf_rD),      64'(vec[i].rdx));
      chk($sformatf("v%0d_ppp", i),   64'(rf_ppp),     64'(vec[i].pppx));
      chk($sformatf("v%0d_d_in", i),  64'(rf_d_in),    vec[i].dx);
      chk($sformatf("v%0d_busyA", i), 64'(busy_A),     64'(vec[i].ba));
      chk($sformatf("v%0d_busyB", i), 64'(busy_B),     64'(vec[i].bb));
      chk($sformatf("v%0d_idle", i),  64'(idle),       64'(vec[i].idl));
      tick();
    end

    // ---------------- contention and backpressure ----------------
    drive_idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n0 = 0; n1 = 0; iss = 0; first = -1; last = -1; drop_at = -1; drop_seen = 1'b0;
    for (int i = 0; i < 12; i++) seq[i] = '0;
    for (int cyc = 0; cyc < 60 && iss < 12; cyc++) begin
      req0_valid = (n0 < 6); req0_rd = 5'd1; req0_ppp = 3'b000; req0_data = 64'h1000 + 64'(n0);
      req1_valid = (n1 < 6); req1_rd = 5'd2; req1_ppp = 3'b101; req1_data = 64'h2000 + 64'(n1);
      #1;
      if (rf_wrEn) begin
        seq[iss] = rf_rD;
        if (first < 0) first = cyc;
        last = cyc;
        iss++;
        if (rf_rD == 5'd1) begin
          chk("sb_q0_nonempty", 64'(q0.size() > 0), 64'd1);
          if (q0.size() > 0) chk("sb_q0_data", 64'(rf_d_in), q0.pop_front());
          chk("sb_q0_ppp", 64'(rf_ppp), 64'd0);
        end else begin
          chk("sb_q1_nonempty", 64'(q1.size() > 0), 64'd1);
          if (q1.size() > 0) chk("sb_q1_data", 64'(rf_d_in), q1.pop_front());
          chk("sb_q1_ppp", 64'(rf_ppp), 64'd5);
        end
      end
      if (req1_valid && !req1_ready && !drop_seen) begin
        drop_seen = 1'b1;
        drop_at = n1;
      end
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      tick();
      if (hs0) begin q0.push_back(64'h1000 + 64'(n0)); n0++; end
      if (hs1) begin q1.push_back(64'h2000 + 64'(n1)); n1++; end
    end
    drive_idle();
    chk("cont_issued", 64'(iss), 64'd12);
    chk("cont_span", 64'(last - first), 64'd11);
    chk("cont_q0_drained", 64'(q0.size()), 64'd0);
    chk("cont_q1_drained", 64'(q1.size()), 64'd0);
    chk("bp_rdy1_drop_after", 64'(drop_at), 64'd2);
    for (int i = 0; i < 12; i++) begin
`ifdef RF_WB_RR_EN
      exp_rd = (i % 2 == 0) ? 5'd1 : 5'd2;
`else
      exp_rd = (i < 6) ? 5'd1 : 5'd2;
`endif
      chk($sformatf("cont_order%0d", i), 64'(seq[i]), 64'(exp_rd));
    end
    tick();
    chk("cont_idle_end", 64'(idle), 64'd1);

    // ---------------- reset mid-stream ----------------
    req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 64'hA;
    req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 64'hB;
    tick();
    req0_rd = 5'd12; req0_data = 64'hC;
    req1_rd = 5'd13; req1_data = 64'hD;
    tick();
    drive_idle();
    query_rA = 5'd12;
    query_rB = 5'd11;
    #1;
    chk("mid_busy_before", 64'(busy_A & busy_B & rf_wrEn), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rdy0_in_reset", 64'(req0_ready), 64'd0);
    tick();
    chk("mid_wrEn",  64'(rf_wrEn), 64'd0);
    chk("mid_idle",  64'(idle), 64'd1);
    chk("mid_busyA", 64'(busy_A), 64'd0);
    chk("mid_busyB", 64'(busy_B), 64'd0);
    chk("mid_rD",    64'(rf_rD), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mid_after%0d_wrEn", i), 64'(rf_wrEn), 64'd0);
      chk($sformatf("mid_after%0d_idle", i), 64'(idle), 64'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
